// File: rtl/tugowar_referee.sv
// rtl/tugowar_referee.sv - tug-of-war round engine producing the marker LEDs and the done/winner result
module tugowar_referee #(
  parameter int NUM_LIGHTS     = 9,
  parameter int LOCKOUT_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  l_press,
  input  logic                  r_press,
  input  logic                  restart,
  input  logic                  match_over,
  output logic [NUM_LIGHTS-1:0] leds,
  output logic                  done,
  output logic [1:0]            winner
);

  localparam int C  = (NUM_LIGHTS - 1) / 2;
  localparam int PW = $clog2(NUM_LIGHTS);
  localparam int CW = (LOCKOUT_CYCLES > 0) ? $clog2(LOCKOUT_CYCLES + 1) : 1;

  localparam logic [PW-1:0]         POS_C    = PW'(C);
  localparam logic [PW-1:0]         POS_MAX  = PW'(NUM_LIGHTS - 1);
  localparam logic [CW-1:0]         CNT_LOAD = CW'(LOCKOUT_CYCLES);
  localparam logic [NUM_LIGHTS-1:0] LED_C    = NUM_LIGHTS'(1) << C;

  typedef enum logic {PLAY, WON} state_t;

  state_t        state;
  logic [PW-1:0] pos;
  logic [CW-1:0] lock_cnt;

  // Round state machine: marker position, lockout timer and the registered result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= PLAY;
      pos      <= POS_C;
      leds     <= LED_C;
      done     <= 1'b0;
      winner   <= 2'b00;
      lock_cnt <= '0;
    end else begin
      // Timer runs down in either state; any later load or clear below overrides it
      if (lock_cnt != '0) begin
        lock_cnt <= lock_cnt - CW'(1);
      end
      case (state)
        PLAY: begin
          if (restart) begin
            // Re-centre takes priority over a press arriving in the same cycle
            pos      <= POS_C;
            leds     <= LED_C;
            lock_cnt <= '0;
          end else if (lock_cnt == '0) begin
            if (l_press && !r_press) begin
              lock_cnt <= CNT_LOAD;
              if (pos < POS_MAX) begin
                pos  <= pos + PW'(1);
                leds <= {leds[NUM_LIGHTS-2:0], 1'b0};
              end else begin
                state  <= WON;
                done   <= 1'b1;
                winner <= 2'b01;
              end
            end else if (r_press && !l_press) begin
              lock_cnt <= CNT_LOAD;
              if (pos > '0) begin
                pos  <= pos - PW'(1);
                leds <= {1'b0, leds[NUM_LIGHTS-1:1]};
              end else begin
                state  <= WON;
                done   <= 1'b1;
                winner <= 2'b10;
              end
            end
          end
        end
        WON: begin
          // Result is frozen; only a restart outside a finished match reopens play
          if (restart && !match_over) begin
            state    <= PLAY;
            pos      <= POS_C;
            leds     <= LED_C;
            done     <= 1'b0;
            winner   <= 2'b00;
            lock_cnt <= '0;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule
